alu_commit: RTL and testbench

Commit stage directly downstream of the ALU: registers one ALU result and its status word, then on a commit strobe merges the result into the 8-entry GPR file and the architectural status register. The status register drives the ALU's `status_in`, and two read ports with forwarding supply `opnd0_r`/`opnd1_r` sources. Sub-register writes (AL/AH/AX/EAX) are handled here, not in the ALU.

---
 rtl/alu_commit_pkg.sv | 43 ++++
 rtl/alu_commit_gpr_merge.sv | 29 ++
 rtl/alu_commit.sv | 107 ++++++++++
 tb/tb_alu_commit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_commit_pkg.sv
// Shared constants for the ALU commit stage: status bit indices, destination
// width encodings, GPR indices and the stage-register payload.
package alu_commit_pkg;

  localparam int STAT_W  = 7;
  localparam int STAT_CF = 0;
  localparam int STAT_PF = 1;
  localparam int STAT_AF = 2;
  localparam int STAT_ZF = 3;
  localparam int STAT_SF = 4;
  localparam int STAT_OF = 5;
  localparam int STAT_DF = 6;

  typedef enum logic [1:0] {
    W_BYTE  = 2'b00,
    W_WORD  = 2'b01,
    W_DWORD = 2'b10,
    W_RSVD  = 2'b11
  } width_e;

  typedef enum logic [2:0] {
    R_EAX = 3'd0,
    R_ECX = 3'd1,
    R_EDX = 3'd2,
    R_EBX = 3'd3,
    R_ESP = 3'd4,
    R_EBP = 3'd5,
    R_ESI = 3'd6,
    R_EDI = 3'd7
  } gpr_e;

  // The destination index lives outside this struct because its width
  // follows the NREGS parameter of the top.
  typedef struct packed {
    logic [31:0]       result;
    logic [STAT_W-1:0] status;
    logic [1:0]        width;
    logic              hi8;
    logic              gpr_wr;
    logic              flags_wr;
  } stage_t;

endpackage

// File: rtl/alu_commit_gpr_merge.sv
// Sub-register merge: overlays an ALU result onto an old GPR value according
// to the destination width; reserved width leaves the value alone and flags it.
module gpr_merge
  import alu_commit_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] result_i,
  input  logic [1:0]  width_i,
  input  logic        hi8_i,
  output logic [31:0] new_o,
  output logic        err_o
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    new_o = old_i;
    err_o = 1'b0;
    case (width_i)
      W_BYTE: begin
        if (hi8_i) new_o[15:8] = result_i[7:0];
        else       new_o[7:0]  = result_i[7:0];
      end
      W_WORD:  new_o[15:0] = result_i[15:0];
      W_DWORD: new_o       = result_i;
      default: err_o       = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_commit.sv
// Commit stage behind the ALU: one-entry stage register, GPR file with
// sub-register merge, architectural status register and forwarding read ports.
module alu_commit
  import alu_commit_pkg::*;
#(
  parameter  int NREGS = 8,
  localparam int IDX_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       result,
  input  logic [STAT_W-1:0] status_new,
  input  logic [IDX_W-1:0]  dest_reg,
  input  logic [1:0]        dest_width,
  input  logic              dest_hi8,
  input  logic              gpr_wr,
  input  logic              flags_wr,
  input  logic              commit_en,
  input  logic [IDX_W-1:0]  rd_a,
  input  logic [IDX_W-1:0]  rd_b,
  output logic [31:0]       rd_a_data,
  output logic [31:0]       rd_b_data,
  output logic [STAT_W-1:0] status_q,
  output logic              pending,
  output logic [31:0]       retire_cnt,
  output logic              width_err
);

  logic [31:0]       gpr_q [NREGS];
  stage_t            stage_q, stage_d;
  logic [IDX_W-1:0]  dest_q;
  logic              pending_q;
  logic [31:0]       retire_cnt_q;
  logic              width_err_q;
  logic [STAT_W-1:0] status_d;
  logic [31:0]       merged;
  logic              merge_err;
  logic              capture, retire, fwd_a, fwd_b;

  assign in_ready = ~pending_q | commit_en;
  assign capture  = in_valid & in_ready;
  assign retire   = pending_q & commit_en;

  assign stage_d = '{result:   result,
                     status:   status_new,
                     width:    dest_width,
                     hi8:      dest_hi8,
                     gpr_wr:   gpr_wr,
                     flags_wr: flags_wr};

  // A forwarding hit means rd_x == dest_q, so the one merge of the destination
  // register serves the write port and both read ports.
  gpr_merge u_merge (
    .old_i    (gpr_q[dest_q]),
    .result_i (stage_q.result),
    .width_i  (stage_q.width),
    .hi8_i    (stage_q.hi8),
    .new_o    (merged),
    .err_o    (merge_err)
  );

  assign fwd_a     = pending_q & stage_q.gpr_wr & (rd_a == dest_q);
  assign fwd_b     = pending_q & stage_q.gpr_wr & (rd_b == dest_q);
  assign rd_a_data = fwd_a ? merged : gpr_q[rd_a];
  assign rd_b_data = fwd_b ? merged : gpr_q[rd_b];

  // DF is owned by the architectural register; the ALU's copy is never trusted.
  always_comb begin
    status_d          = stage_q.status;
    status_d[STAT_DF] = status_q[STAT_DF];
  end

  // NOTE: the GPR file is architecturally visible and must read 0 after reset,
  // so unlike a plain data RAM it is cleared in the reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) gpr_q[i] <= '0;
      stage_q      <= '0;
      dest_q       <= '0;
      pending_q    <= 1'b0;
      status_q     <= '0;
      retire_cnt_q <= '0;
      width_err_q  <= 1'b0;
    end else begin
      if (retire) begin
        retire_cnt_q <= retire_cnt_q + 32'd1;
        if (stage_q.gpr_wr && !merge_err) gpr_q[dest_q] <= merged;
        if (stage_q.gpr_wr && merge_err)  width_err_q   <= 1'b1;
        if (stage_q.flags_wr)             status_q      <= status_d;
      end
      if (capture) begin
        stage_q   <= stage_d;
        dest_q    <= dest_reg;
        pending_q <= 1'b1;
      end else if (retire) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign pending    = pending_q;
  assign retire_cnt = retire_cnt_q;
  assign width_err  = width_err_q;

endmodule

// File: tb/tb_alu_commit.sv
// Bench for alu_commit: table of single ops with hand-derived register values,
// plus sequences for stall/back-to-back, flags, reserved width, reset and wrap.
module tb_alu_commit;
  import alu_commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] result;
  logic [6:0]  status_new;
  logic [2:0]  dest_reg;
  logic [1:0]  dest_width;
  logic        dest_hi8, gpr_wr, flags_wr, commit_en;
  logic [2:0]  rd_a, rd_b;
  logic [31:0] rd_a_data, rd_b_data;
  logic [6:0]  status_q;
  logic        pending;
  logic [31:0] retire_cnt;
  logic        width_err;

  always #5 clk = ~clk;

  alu_commit #(.NREGS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .result     (result),
    .status_new (status_new),
    .dest_reg   (dest_reg),
    .dest_width (dest_width),
    .dest_hi8   (dest_hi8),
    .gpr_wr     (gpr_wr),
    .flags_wr   (flags_wr),
    .commit_en  (commit_en),
    .rd_a       (rd_a),
    .rd_b       (rd_b),
    .rd_a_data  (rd_a_data),
    .rd_b_data  (rd_b_data),
    .status_q   (status_q),
    .pending    (pending),
    .retire_cnt (retire_cnt),
    .width_err  (width_err)
  );

  typedef struct {
    logic [31:0] result;
    logic [6:0]  status;
    logic [2:0]  dest;
    logic [1:0]  width;
    logic        hi8;
    logic        gpr_wr;
    logic        flags_wr;
    logic [31:0] exp_val;
  } vec_t;

  typedef struct {
    logic [2:0]  dest;
    logic [31:0] val;
  } exp_t;

  vec_t        vecs[9];
  exp_t        sb_q[$];
  logic [31:0] model_gpr[8];
  int unsigned exp_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    result     = v.result;
    status_new = v.status;
    dest_reg   = v.dest;
    dest_width = v.width;
    dest_hi8   = v.hi8;
    gpr_wr     = v.gpr_wr;
    flags_wr   = v.flags_wr;
  endtask

  function automatic vec_t mk(input logic [31:0] res, input logic [2:0] dst, input logic [1:0] w,
                              input logic h, input logic gw, input logic [31:0] ev);
    vec_t v;
    v.result = res; v.status = 7'h00; v.dest = dst; v.width = w; v.hi8 = h;
    v.gpr_wr = gw; v.flags_wr = 1'b0; v.exp_val = ev;
    return v;
  endfunction

  // Scoreboard pop: the retired destination must now hold the expected value.
  task automatic retire_check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e    = sb_q.pop_front();
    rd_a = e.dest;
    #1;
    check(name, rd_a_data, e.val);
    model_gpr[e.dest] = e.val;
  endtask

  task automatic run_op(input string name, input vec_t v);
    @(negedge clk);
    check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    drive(v);
    in_valid  = 1'b1;
    commit_en = 1'b0;
    sb_q.push_back('{dest: v.dest, val: v.exp_val});
    @(negedge clk);
    in_valid = 1'b0;
    check({name, "_pending"}, {31'd0, pending}, 32'd1);
    rd_a = v.dest;
    rd_b = v.dest;
    #1;
    check({name, "_fwd_a"}, rd_a_data, v.exp_val);
    check({name, "_fwd_b"}, rd_b_data, v.exp_val);
    rd_b = v.dest ^ 3'd1;
    #1;
    check({name, "_other"}, rd_b_data, model_gpr[v.dest ^ 3'd1]);
    commit_en = 1'b1;
    @(negedge clk);
    commit_en = 1'b0;
    exp_cnt++;
    retire_check({name, "_retired"});
    check({name, "_cnt"}, retire_cnt, exp_cnt);
    check({name, "_idle"}, {31'd0, pending}, 32'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = mk(32'h1234_5678, R_EAX, W_DWORD, 1'b0, 1'b1, 32'h1234_5678);
    vecs[1] = mk(32'hFFFF_FFAB, R_EAX, W_BYTE,  1'b1, 1'b1, 32'h1234_AB78);
    vecs[2] = mk(32'hDEAD_BEEF, R_ECX, W_WORD,  1'b0, 1'b1, 32'h0000_BEEF);
    vecs[3] = mk(32'h1234_5611, R_ECX, W_BYTE,  1'b0, 1'b1, 32'h0000_BE11);
    vecs[4] = mk(32'hCAFE_1234, R_EDX, W_WORD,  1'b1, 1'b1, 32'h0000_1234);
    vecs[5] = mk(32'hFFFF_FFFF, R_EDI, W_DWORD, 1'b0, 1'b1, 32'hFFFF_FFFF);
    vecs[6] = mk(32'hFFFF_FF00, R_EDI, W_BYTE,  1'b0, 1'b1, 32'hFFFF_FF00);
    vecs[7] = mk(32'h0000_005A, R_EDI, W_BYTE,  1'b1, 1'b1, 32'hFFFF_5A00);
    vecs[8] = mk(32'h0000_0000, R_EAX, W_DWORD, 1'b0, 1'b0, 32'h1234_AB78);

    for (int i = 0; i < 8; i++) model_gpr[i] = '0;
    exp_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; commit_en = 1'b0;
    result = '0; status_new = '0; dest_reg = '0; dest_width = '0;
    dest_hi8 = 1'b0; gpr_wr = 1'b0; flags_wr = 1'b0; rd_a = '0; rd_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 8; r++) begin
      rd_a = 3'(r);
      rd_b = 3'(7 - r);
      #1;
      check("reset_gpr_a", rd_a_data, 32'd0);
      check("reset_gpr_b", rd_b_data, 32'd0);
    end
    check("reset_status", {25'd0, status_q}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_cnt", retire_cnt, 32'd0);
    check("reset_pending", {31'd0, pending}, 32'd0);
    check("reset_werr", {31'd0, width_err}, 32'd0);

    for (int i = 0; i < 9; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Stall, then simultaneous retire of A and capture of B.
    @(negedge clk);
    drive(mk(32'h1111_1111, R_EBX, W_DWORD, 1'b0, 1'b1, 32'h1111_1111));
    in_valid = 1'b1;
    sb_q.push_back('{dest: R_EBX, val: 32'h1111_1111});
    @(negedge clk);
    drive(mk(32'h0000_2222, R_ECX, W_WORD, 1'b0, 1'b1, 32'h0000_2222));
    sb_q.push_back('{dest: R_ECX, val: 32'h0000_2222});
    rd_a = R_ECX;
    #1;
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("stall_b_not_captured", rd_a_data, 32'h0000_BE11);
    check("stall_cnt", retire_cnt, exp_cnt);
    commit_en = 1'b1;
    #1;
    check("stall_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    commit_en = 1'b0;
    exp_cnt++;
    check("b2b_pending", {31'd0, pending}, 32'd1);
    check("b2b_cnt", retire_cnt, exp_cnt);
    retire_check("b2b_a_retired");
    rd_b = R_ECX;
    #1;
    check("b2b_b_fwd", rd_b_data, 32'h0000_2222);
    commit_en = 1'b1;
    @(negedge clk);
    commit_en = 1'b0;
    exp_cnt++;
    retire_check("b2b_b_retired");
    check("b2b_cnt2", retire_cnt, exp_cnt);

    // Flags: DF always comes from the architectural register (currently 0).
    v = mk(32'hFFFF_FFFF, R_EAX, W_DWORD, 1'b0, 1'b0, 32'h1234_AB78);
    v.status   = 7'h7F;
    v.flags_wr = 1'b1;
    run_op("flags_ones", v);
    check("flags_ones_status", {25'd0, status_q}, {25'd0, 7'h7F & ~(7'd1 << STAT_DF)});
    v.status = 7'h15;
    run_op("flags_mix", v);
    check("flags_mix_status", {25'd0, status_q}, {25'd0, 7'h15 & ~(7'd1 << STAT_DF)});

    // Reserved width: no write, sticky error.
    run_op("ecx_55", mk(32'h0000_0055, R_ECX, W_DWORD, 1'b0, 1'b1, 32'h0000_0055));
    check("werr_before", {31'd0, width_err}, 32'd0);
    run_op("rsvd", mk(32'hFFFF_FFFF, R_ECX, W_RSVD, 1'b0, 1'b1, 32'h0000_0055));
    check("werr_set", {31'd0, width_err}, 32'd1);
    run_op("after_rsvd", mk(32'h0000_00C3, R_EDX, W_BYTE, 1'b0, 1'b1, 32'h0000_12C3));
    check("werr_sticky", {31'd0, width_err}, 32'd1);

    // Asynchronous reset with an op pending discards it.
    @(negedge clk);
    drive(mk(32'h9999_9999, R_ESI, W_DWORD, 1'b0, 1'b1, 32'h9999_9999));
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_pre_pending", {31'd0, pending}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_pending", {31'd0, pending}, 32'd0);
    commit_en = 1'b1;
    @(negedge clk);
    commit_en = 1'b0;
    rst_n     = 1'b1;
    exp_cnt   = 0;
    sb_q.delete();
    for (int i = 0; i < 8; i++) model_gpr[i] = '0;
    rd_a = R_ESI;
    rd_b = R_EAX;
    #1;
    check("rst_esi", rd_a_data, 32'd0);
    check("rst_eax", rd_b_data, 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    check("rst_werr", {31'd0, width_err}, 32'd0);
    check("rst_status", {25'd0, status_q}, 32'd0);

    // Counter wrap.
    @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    check("wrap_preload", retire_cnt, 32'hFFFF_FFFF);
    exp_cnt = 32'hFFFF_FFFF;
    run_op("wrap", mk(32'hA5A5_0F0F, R_EBP, W_DWORD, 1'b0, 1'b1, 32'hA5A5_0F0F));
    check("wrap_zero", retire_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
